// File: rtl/uart_tx_engine.sv
// UART transmit engine: pulls bytes from a TX FIFO and serialises them as
// start / 8 data (LSB first) / optional parity / 1-2 stop bits.
module uart_tx_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_en,
  input  logic        cfg_parity_en,
  input  logic        cfg_parity_odd,
  input  logic        cfg_two_stop,
  input  logic [15:0] clk_div,
  input  logic        fifo_empty,
  output logic        fifo_ren,
  input  logic [7:0]  fifo_rdata,
  output logic        uart_tx,
  output logic        busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic        par_en_q, par_en_d;
  logic        par_bit_q, par_bit_d;
  logic        two_stop_q, two_stop_d;
  logic        armed_q;
  logic        tx_q, tx_d;
  logic        ren_q, busy_q, done_q, done_d;
  logic        bit_end;

  assign bit_end = (cnt_q == div_q - 16'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    tx_d       = 1'b1;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // armed_q holds off the first LOAD until one edge after reset release
        if (cfg_en && !fifo_empty && armed_q) state_d = LOAD;
      end
      LOAD: begin
        state_d    = START;
        shift_d    = fifo_rdata;
        div_d      = (clk_div < 16'd16) ? 16'd16 : clk_div;
        par_en_d   = cfg_parity_en;
        par_bit_d  = (^fifo_rdata) ^ cfg_parity_odd;
        two_stop_d = cfg_two_stop;
        cnt_d      = 16'd0;
        idx_d      = 3'd0;
        stop_idx_d = 1'b0;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = 16'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = 16'd0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = 16'd0;
          if (stop_idx_q == two_stop_q) begin
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered pins line up with it
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
    done_d = (state_d == STOP) && (stop_idx_d == two_stop_q) && (cnt_d == div_q - 16'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      div_q      <= 16'd0;
      shift_q    <= 8'd0;
      idx_q      <= 3'd0;
      stop_idx_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      armed_q    <= 1'b0;
      tx_q       <= 1'b1;
      ren_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      armed_q    <= 1'b1;
      tx_q       <= tx_d;
      ren_q      <= (state_d == LOAD);
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
    end
  end

  assign uart_tx  = tx_q;
  assign fifo_ren = ren_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scenario bench for uart_tx_engine: a small FIFO model feeds bytes, a line
// logger records every cycle, and expected frames are scored from a queue.
module tb_uart_tx_engine;

  localparam int LOGN = 16384;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       po;
    logic       ts;
    int         div;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_en, cfg_parity_en, cfg_parity_odd, cfg_two_stop;
  logic [15:0] clk_div;
  logic        fifo_empty, fifo_ren;
  logic [7:0]  fifo_rdata;
  logic        uart_tx, busy, tx_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  logic log_tx   [0:LOGN-1];
  logic log_busy [0:LOGN-1];
  int   ren_q[$];
  int   done_q[$];
  exp_t exp_q[$];

  uart_tx_engine dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_en         (cfg_en),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_two_stop   (cfg_two_stop),
    .clk_div        (clk_div),
    .fifo_empty     (fifo_empty),
    .fifo_ren       (fifo_ren),
    .fifo_rdata     (fifo_rdata),
    .uart_tx        (uart_tx),
    .busy           (busy),
    .tx_done        (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = mem[rd_ptr % 64];
  always @(posedge clk) if (fifo_ren === 1'b1) rd_ptr <= rd_ptr + 1;

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      log_tx[cyc]   = uart_tx;
      log_busy[cyc] = busy;
    end
    if (fifo_ren === 1'b1) ren_q.push_back(cyc);
    if (tx_done === 1'b1) done_q.push_back(cyc);
  end

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1);
  end

  function automatic int nbits(exp_t e);
    return 10 + (e.pe ? 1 : 0) + (e.ts ? 1 : 0);
  endfunction

  function automatic logic exp_line(exp_t e, int t);
    int b;
    b = t / e.div;
    if (b == 0) return 1'b0;
    if (b <= 8) return e.d[b-1];
    if (e.pe && b == 9) return (^e.d) ^ e.po;
    return 1'b1;
  endfunction

  function automatic int frame_err(exp_t e, int s);
    int n;
    n = 0;
    for (int t = 0; t < nbits(e) * e.div; t++)
      if (s + t >= LOGN || log_tx[s+t] !== exp_line(e, t)) n++;
    return n;
  endfunction

  function automatic int busy_err(int a, int b);
    int n;
    n = 0;
    for (int t = a; t <= b; t++)
      if (t >= LOGN || log_busy[t] !== 1'b1) n++;
    return n;
  endfunction

  task automatic push_byte(input logic [7:0] d, input int div);
    exp_t e;
    mem[wr_ptr % 64] = d;
    wr_ptr++;
    e.d = d; e.pe = cfg_parity_en; e.po = cfg_parity_odd; e.ts = cfg_two_stop; e.div = div;
    exp_q.push_back(e);
  endtask

  task automatic setup(input logic pe, input logic po, input logic ts, input logic [15:0] div);
    cfg_en = 1'b1; cfg_parity_en = pe; cfg_parity_odd = po; cfg_two_stop = ts; clk_div = div;
    repeat (4) @(negedge clk);
    ren_q.delete(); done_q.delete(); exp_q.delete();
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (done_q.size() >= n) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    ok = (done_q.size() >= n);
  endtask

  task automatic test_reset;
    exp_t e; int r, rs, d; bit ok;
    reset = 1'b1; cfg_en = 1'b0; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;
    cfg_two_stop = 1'b0; clk_div = 16'd16;
    repeat (3) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b want 0", fifo_ren); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
    cfg_en = 1'b1;
    ren_q.delete(); done_q.delete(); exp_q.delete();
    push_byte(8'h5A, 16);
    @(negedge clk);
    rs = cyc;
    reset = 1'b0;
    wait_frames(1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL startup_timeout done=%0d want 1", done_q.size()); return; end
    e = exp_q.pop_front(); r = ren_q.pop_front(); d = done_q.pop_front();
    checks++; if (r < rs + 2) begin errors++; $display("FAIL startup_ren cycle %0d want >= %0d", r, rs + 2); end
    checks++; if (frame_err(e, r + 1) !== 0) begin errors++; $display("FAIL startup_frame bad cycles %0d want 0", frame_err(e, r + 1)); end
  endtask

  task automatic test_basic;
    exp_t e; int n, r, d; bit ok;
    setup(1'b0, 1'b0, 1'b0, 16'd16);
    @(posedge clk); #1;
    n = cyc;
    push_byte(8'h55, 16);
    wait_frames(1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout done=%0d want 1", done_q.size()); return; end
    e = exp_q.pop_front(); r = ren_q.pop_front(); d = done_q.pop_front();
    checks++; if (r !== n + 1) begin errors++; $display("FAIL basic_ren cycle %0d want %0d", r, n + 1); end
    checks++; if (d !== n + 161) begin errors++; $display("FAIL basic_done cycle %0d want %0d", d, n + 161); end
    checks++; if (frame_err(e, r + 1) !== 0) begin errors++; $display("FAIL basic_frame bad cycles %0d want 0", frame_err(e, r + 1)); end
    checks++; if (busy_err(r, d) !== 0) begin errors++; $display("FAIL basic_busy low cycles %0d want 0", busy_err(r, d)); end
    checks++; if (log_busy[d+1] !== 1'b0 || log_tx[d+1] !== 1'b1) begin errors++; $display("FAIL basic_idle busy=%b tx=%b want 0 1", log_busy[d+1], log_tx[d+1]); end
    checks++; if (ren_q.size() + done_q.size() !== 0) begin errors++; $display("FAIL basic_extra pulses %0d want 0", ren_q.size() + done_q.size()); end
  endtask

  task automatic test_parity;
    logic [7:0] bytes [3];
    logic       odds  [3];
    logic       pexp  [3];
    exp_t e; int r, d; bit ok;
    bytes[0] = 8'h07; odds[0] = 1'b0; pexp[0] = 1'b1;
    bytes[1] = 8'h00; odds[1] = 1'b1; pexp[1] = 1'b1;
    bytes[2] = 8'hFF; odds[2] = 1'b0; pexp[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setup(1'b1, odds[i], 1'b0, 16'd16);
      push_byte(bytes[i], 16);
      wait_frames(1, 400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL parity_timeout frame %0d", i); continue; end
      e = exp_q.pop_front(); r = ren_q.pop_front(); d = done_q.pop_front();
      checks++; if (d - r !== 176) begin errors++; $display("FAIL parity_len frame %0d got %0d want 176", i, d - r); end
      checks++; if (log_tx[r+1+9*16+8] !== pexp[i]) begin errors++; $display("FAIL parity_bit frame %0d got %b want %b", i, log_tx[r+1+9*16+8], pexp[i]); end
      checks++; if (frame_err(e, r + 1) !== 0) begin errors++; $display("FAIL parity_frame frame %0d bad cycles %0d", i, frame_err(e, r + 1)); end
    end
  endtask

  task automatic test_two_stop;
    exp_t e; int r, d; bit ok;
    setup(1'b0, 1'b0, 1'b1, 16'd20);
    push_byte(8'h81, 20);
    wait_frames(1, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL twostop_timeout"); return; end
    e = exp_q.pop_front(); r = ren_q.pop_front(); d = done_q.pop_front();
    checks++; if (d - r !== 220) begin errors++; $display("FAIL twostop_len got %0d want 220", d - r); end
    checks++; if (frame_err(e, r + 1) !== 0) begin errors++; $display("FAIL twostop_frame bad cycles %0d want 0", frame_err(e, r + 1)); end
  endtask

  task automatic test_div_change;
    exp_t e1, e2; int r1, d1, r2, d2; bit ok;
    setup(1'b0, 1'b0, 1'b0, 16'd3);
    push_byte(8'h3B, 16);
    push_byte(8'hE4, 40);
    for (int i = 0; i < 100 && ren_q.size() == 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    clk_div = 16'd40;
    wait_frames(2, 1500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL div_timeout done=%0d want 2", done_q.size()); return; end
    e1 = exp_q.pop_front(); r1 = ren_q.pop_front(); d1 = done_q.pop_front();
    e2 = exp_q.pop_front(); r2 = ren_q.pop_front(); d2 = done_q.pop_front();
    checks++; if (d1 - r1 !== 160) begin errors++; $display("FAIL div_clamp_len got %0d want 160", d1 - r1); end
    checks++; if (d2 - r2 !== 400) begin errors++; $display("FAIL div_next_len got %0d want 400", d2 - r2); end
    checks++; if (frame_err(e1, r1 + 1) + frame_err(e2, r2 + 1) !== 0) begin errors++; $display("FAIL div_frames bad cycles %0d want 0", frame_err(e1, r1 + 1) + frame_err(e2, r2 + 1)); end
  endtask

  task automatic test_back_to_back;
    exp_t e1, e2; int r1, d1, r2, d2; bit ok;
    setup(1'b0, 1'b0, 1'b0, 16'd16);
    push_byte(8'hA5, 16);
    push_byte(8'h3C, 16);
    wait_frames(2, 800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout done=%0d want 2", done_q.size()); return; end
    checks++; if (ren_q.size() !== 2) begin errors++; $display("FAIL b2b_ren_count got %0d want 2", ren_q.size()); return; end
    e1 = exp_q.pop_front(); r1 = ren_q.pop_front(); d1 = done_q.pop_front();
    e2 = exp_q.pop_front(); r2 = ren_q.pop_front(); d2 = done_q.pop_front();
    checks++; if (r2 !== d1 + 2) begin errors++; $display("FAIL b2b_gap ren %0d want %0d", r2, d1 + 2); end
    checks++; if (log_tx[d1+1] !== 1'b1 || log_tx[d1+2] !== 1'b1) begin errors++; $display("FAIL b2b_idle_high got %b%b want 11", log_tx[d1+1], log_tx[d1+2]); end
    checks++; if (frame_err(e1, r1 + 1) !== 0) begin errors++; $display("FAIL b2b_frame1 bad cycles %0d want 0", frame_err(e1, r1 + 1)); end
    checks++; if (frame_err(e2, r2 + 1) !== 0 || d2 - r2 !== 160) begin errors++; $display("FAIL b2b_frame2 bad cycles %0d len %0d want 0 160", frame_err(e2, r2 + 1), d2 - r2); end
  endtask

  task automatic test_cfg_en_fall;
    exp_t e; int r, d; bit ok;
    setup(1'b0, 1'b0, 1'b0, 16'd16);
    push_byte(8'h11, 16);
    push_byte(8'h22, 16);
    for (int i = 0; i < 100 && ren_q.size() == 0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    cfg_en = 1'b0;
    wait_frames(1, 400, ok);
    repeat (60) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL en_fall_timeout"); return; end
    checks++; if (ren_q.size() !== 1 || done_q.size() !== 1) begin errors++; $display("FAIL en_fall_stop ren=%0d done=%0d want 1 1", ren_q.size(), done_q.size()); return; end
    e = exp_q.pop_front(); r = ren_q.pop_front(); d = done_q.pop_front();
    checks++; if (frame_err(e, r + 1) !== 0 || d - r !== 160) begin errors++; $display("FAIL en_fall_frame bad cycles %0d len %0d", frame_err(e, r + 1), d - r); end
    cfg_en = 1'b1;
    wait_frames(1, 400, ok);
    checks++; if (!ok || ren_q.size() == 0) begin errors++; $display("FAIL en_resume_timeout done=%0d want 1", done_q.size()); return; end
    e = exp_q.pop_front(); r = ren_q.pop_front(); d = done_q.pop_front();
    checks++; if (frame_err(e, r + 1) !== 0) begin errors++; $display("FAIL en_resume_frame bad cycles %0d want 0", frame_err(e, r + 1)); end
  endtask

  task automatic test_reset_mid_frame;
    exp_t e; int r, d; bit ok;
    setup(1'b0, 1'b0, 1'b0, 16'd16);
    mem[wr_ptr % 64] = 8'hC3;
    wr_ptr++;
    for (int i = 0; i < 100 && ren_q.size() == 0; i++) @(negedge clk);
    checks++; if (ren_q.size() == 0) begin errors++; $display("FAIL rstmid_no_load"); return; end
    r = ren_q[0];
    while (cyc < r + 70) @(negedge clk);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL rstmid_bit3 got %b want 0", uart_tx); end
    #1 reset = 1'b1;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", uart_tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL rstmid_done pulses %0d want 0", done_q.size()); end
    ren_q.delete(); done_q.delete(); exp_q.delete();
    push_byte(8'h96, 16);
    wait_frames(1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_next_timeout"); return; end
    e = exp_q.pop_front(); r = ren_q.pop_front(); d = done_q.pop_front();
    checks++; if (frame_err(e, r + 1) !== 0 || d - r !== 160) begin errors++; $display("FAIL rstmid_next_frame bad cycles %0d len %0d want 0 160", frame_err(e, r + 1), d - r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_div_change();
    test_back_to_back();
    test_cfg_en_fall();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port cfg_en, input, 1; transmitter enable, level.
REQ-004 SHALL have port cfg_parity_en, input, 1; 1 = insert parity bit after data.
REQ-005 SHALL have port cfg_parity_odd, input, 1; 1 = odd parity, 0 = even parity.
REQ-006 SHALL have port cfg_two_stop, input, 1; 1 = two stop bits, 0 = one.
REQ-007 SHALL have port clk_div, input, 16; bit period in clk cycles.
REQ-008 SHALL have port fifo_empty, input, 1; TX FIFO empty flag.
REQ-009 SHALL have port fifo_ren, output, 1; TX FIFO read strobe, one-cycle pulse.
REQ-010 SHALL have port fifo_rdata, input, 8; FIFO head byte, valid combinationally while fifo_ren=1.
REQ-011 SHALL have port uart_tx, output, 1; serial line, idle high.
REQ-012 SHALL have port busy, output, 1; high in every state except IDLE.
REQ-013 SHALL have port tx_done, output, 1; one-cycle pulse at frame end.

Function
REQ-014 SHALL implement states IDLE, LOAD, START, DATA, PARITY, STOP.
REQ-015 IDLE -> LOAD SHALL occur when cfg_en=1 and fifo_empty=0 at a clock edge; otherwise the FSM stays in IDLE.
REQ-016 fifo_ren SHALL be 1 exactly during the single LOAD cycle (Moore decode), 0 otherwise.
REQ-017 At the end of LOAD, the FSM SHALL capture fifo_rdata into the shift register and latch the effective divider and all cfg_* bits for the whole frame.
REQ-018 The effective divider SHALL be max(clk_div, 16); values 0..15 SHALL be treated as 16.
REQ-019 A 16-bit bit-period counter SHALL reload on entry to each bit and advance the FSM when it reaches divider-1; each bit SHALL last exactly divider cycles.
REQ-020 START SHALL drive uart_tx=0 for one bit period, then go to DATA.
REQ-021 DATA SHALL send 8 bits LSB first, counted by a 3-bit index, and exit after bit 7.
REQ-022 After DATA, the FSM SHALL go to PARITY if parity is latched enabled, else to STOP.
REQ-023 The parity bit SHALL be XOR of the 8 data bits for even parity, or its inverse for odd parity.
REQ-024 STOP SHALL drive uart_tx=1 for 1 or 2 bit periods per the latched cfg_two_stop, then return to IDLE.
REQ-025 tx_done SHALL be 1 in the last clk cycle of the final stop bit only.
REQ-026 uart_tx SHALL be 1 in IDLE and LOAD, and SHALL be registered (glitch-free).
REQ-027 Back-to-back frames SHALL have exactly 2 idle-high cycles (IDLE + LOAD) between the last stop bit and the next start bit.
REQ-028 A cfg_en fall mid-frame SHALL let the current frame complete; no further LOAD SHALL occur.
REQ-029 Changes to clk_div or cfg_* after LOAD SHALL not affect the frame in progress.
REQ-030 fifo_empty rising during a frame SHALL have no effect on that frame.

Reset
REQ-031 On reset=1, asynchronously: state=IDLE, uart_tx=1, fifo_ren=0, busy=0, tx_done=0, all counters and the shift register=0.
REQ-032 A reset asserted mid-frame SHALL abort the frame immediately; the byte SHALL be lost and no tx_done SHALL be emitted.
REQ-033 After reset release, the first LOAD SHALL occur no earlier than the second rising edge.

Verification
REQ-034 Frame 0x55, clk_div=16, no parity, 1 stop: fifo_empty falls at edge N -> fifo_ren high in cycle N+1; start bit from N+2; line pattern 0,1,0,1,0,1,0,1,0,1 at 16 cycles each; tx_done in cycle N+161.
REQ-035 Byte 0x07, even parity -> parity bit 1; byte 0x00, odd parity -> parity bit 1; byte 0xFF, even parity -> parity bit 0; each frame is 11 bits.
REQ-036 cfg_two_stop=1, clk_div=20 -> stop high for 40 cycles; total frame is 220 cycles.
REQ-037 clk_div=3 -> each bit lasts 16 cycles; clk_div changed to 40 mid-frame -> the current frame stays at 16-cycle bits and the next frame uses 40.
REQ-038 Two queued bytes 0xA5, 0x3C -> exactly 2 high cycles between frames, two fifo_ren pulses, two tx_done pulses.
REQ-039 reset pulsed during DATA bit 3 -> uart_tx=1 and busy=0 in the same cycle; no tx_done; the next frame starts cleanly after release.
